// File: rtl/dmac_axi_addr_responder.sv
// rtl/dmac_axi_addr_responder.sv - DMA AXI address-channel responder: request FIFO, beat address engine, Gray burst counter
module dmac_axi_addr_responder #(
    parameter int C_ID_WIDTH        = 3,
    parameter int C_ADDR_ALIGN_BITS = 3,
    parameter int C_FIFO_DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  addr_valid_i,
    output logic                  addr_ready_o,
    input  logic [31:0]           addr_i,
    input  logic [7:0]            len_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic [31:0]           beat_addr_o,
    output logic                  beat_last_o,
    output logic [C_ID_WIDTH-1:0] burst_id_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int PW = $clog2(C_FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  mode;
    } req_t;

    typedef enum logic {S_IDLE, S_ACTIVE} state_e;

    function automatic logic [C_ID_WIDTH-1:0] gray_inc(input logic [C_ID_WIDTH-1:0] g);
        logic [C_ID_WIDTH-1:0] b;
        b[C_ID_WIDTH-1] = g[C_ID_WIDTH-1];
        for (int i = C_ID_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        b = b + C_ID_WIDTH'(1);
        return b ^ (b >> 1);
    endfunction

    // Unsupported requests are normalised before storage so the engine only sees legal modes.
    logic size_bad, wrap_ok, req_bad;
    req_t req_in;
    always_comb begin
        size_bad    = size_i > 3'(C_ADDR_ALIGN_BITS);
        wrap_ok     = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
        req_bad     = size_bad || (burst_i == 2'b11) || ((burst_i == 2'b10) && !wrap_ok);
        req_in.addr = addr_i;
        req_in.len  = len_i;
        req_in.size = size_bad ? 3'(C_ADDR_ALIGN_BITS) : size_i;
        if (burst_i == 2'b00)                 req_in.mode = 2'b00;
        else if (burst_i == 2'b10 && wrap_ok) req_in.mode = 2'b10;
        else                                  req_in.mode = 2'b01;
    end

    req_t          mem_q [C_FIFO_DEPTH];
    req_t          head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          addr_ready_q, push, pop, fifo_empty;

    assign push       = addr_valid_i && addr_ready_q;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            addr_ready_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            addr_ready_q <= (count_d != (PW+1)'(C_FIFO_DEPTH));
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= req_in;
    end

    state_e                state_q, state_d;
    logic [31:0]           cur_addr_q, cur_addr_d;
    logic [7:0]            len_q, len_d, cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            mode_q, mode_d;
    logic [C_ID_WIDTH-1:0] bid_q, bid_d;
    logic                  err_q, err_d;
    logic [31:0]           inc, wb, nxt;
    logic                  is_last;

    // Wrap boundary is a power of two because only len in {1,3,7,15} keeps WRAP mode.
    always_comb begin
        inc = 32'd1 << size_q;
        wb  = (32'(len_q) + 32'd1) << size_q;
        case (mode_q)
            2'b00:   nxt = cur_addr_q;
            2'b10:   nxt = (cur_addr_q & ~(wb - 32'd1)) | ((cur_addr_q + inc) & (wb - 32'd1));
            default: nxt = (cur_addr_q & ~(inc - 32'd1)) + inc;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        mode_d     = mode_q;
        bid_d      = bid_q;
        err_d      = err_q | (push & req_bad);
        pop        = 1'b0;
        is_last    = (cnt_q == len_q);
        if ((state_q == S_ACTIVE) && beat_ready_i && !is_last) begin
            cur_addr_d = nxt;
            cnt_d      = cnt_q + 8'd1;
        end else if ((state_q == S_IDLE) || beat_ready_i) begin
            if (state_q == S_ACTIVE) begin
                bid_d   = gray_inc(bid_q);
                state_d = S_IDLE;
            end
            // Loading in the same cycle as the last handshake keeps bursts back-to-back.
            if (!fifo_empty) begin
                pop        = 1'b1;
                state_d    = S_ACTIVE;
                cur_addr_d = head.addr;
                len_d      = head.len;
                size_d     = head.size;
                mode_d     = head.mode;
                cnt_d      = 8'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            mode_q     <= '0;
            bid_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            mode_q     <= mode_d;
            bid_q      <= bid_d;
            err_q      <= err_d;
        end
    end

    assign addr_ready_o = addr_ready_q;
    assign beat_valid_o = (state_q == S_ACTIVE);
    assign beat_addr_o  = cur_addr_q;
    assign beat_last_o  = (state_q == S_ACTIVE) && is_last;
    assign burst_id_o   = bid_q;
    assign busy_o       = !fifo_empty || (state_q == S_ACTIVE);
    assign err_o        = err_q;
endmodule

// File: tb/tb_dmac_axi_addr_responder.sv
// tb/tb_dmac_axi_addr_responder.sv - directed bench with beat-list model for dmac_axi_addr_responder
module tb_dmac_axi_addr_responder;
    localparam int IDW = 3;
    localparam int AB  = 3;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        addr_valid_i = 1'b0;
    logic        addr_ready_o;
    logic [31:0] addr_i = '0;
    logic [7:0]  len_i = '0;
    logic [2:0]  size_i = '0;
    logic [1:0]  burst_i = '0;
    logic        beat_valid_o;
    logic        beat_ready_i = 1'b0;
    logic [31:0] beat_addr_o;
    logic        beat_last_o;
    logic [IDW-1:0] burst_id_o;
    logic        busy_o;
    logic        err_o;

    dmac_axi_addr_responder #(.C_ID_WIDTH(IDW), .C_ADDR_ALIGN_BITS(AB), .C_FIFO_DEPTH(4)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .addr_valid_i(addr_valid_i), .addr_ready_o(addr_ready_o),
        .addr_i(addr_i), .len_i(len_i), .size_i(size_i), .burst_i(burst_i),
        .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
        .beat_addr_o(beat_addr_o), .beat_last_o(beat_last_o),
        .burst_id_o(burst_id_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr_q[$];
    logic        exp_last_q[$];
    logic [31:0] obs_addr[$];
    int          completed = 0;
    logic        exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [IDW-1:0] gray_of(input int n);
        logic [IDW-1:0] b;
        b = IDW'(n);
        return b ^ (b >> 1);
    endfunction

    // Expected beats of one request: start offset walks through the burst, wrapping inside wb.
    task automatic model_push(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        int sz;
        bit wrap, fixed;
        logic [63:0] inc, wb, base, addr64, ad;
        sz    = (s > AB) ? AB : int'(s);
        wrap  = (b == 2'b10) && (l == 1 || l == 3 || l == 7 || l == 15);
        fixed = (b == 2'b00);
        if (b == 2'b11 || (b == 2'b10 && !wrap) || s > AB) exp_err = 1'b1;
        inc    = 64'd1 << sz;
        wb     = (64'(l) + 1) * inc;
        addr64 = 64'(a);
        for (int k = 0; k <= int'(l); k++) begin
            if (fixed)     ad = addr64;
            else if (wrap) begin
                base = addr64 & ~(wb - 1);
                ad   = base + (((addr64 & (wb - 1)) + 64'(k) * inc) % wb);
            end else       ad = (addr64 & ~(inc - 1)) + 64'(k) * inc;
            exp_addr_q.push_back(ad[31:0]);
            exp_last_q.push_back(k == int'(l));
        end
    endtask

    always @(negedge clk) begin
        if (reset_i) begin
            exp_addr_q.delete();
            exp_last_q.delete();
            completed = 0;
            exp_err   = 1'b0;
        end else begin
            check("burst_id", burst_id_o, gray_of(completed));
            check("err", err_o, exp_err);
            check("busy", busy_o, exp_addr_q.size() != 0);
            if (beat_valid_o) begin
                check("beat_expected", exp_addr_q.size() != 0, 1'b1);
                if (exp_addr_q.size() != 0) begin
                    check("beat_addr", beat_addr_o, exp_addr_q[0]);
                    check("beat_last", beat_last_o, exp_last_q[0]);
                    if (beat_ready_i) begin
                        obs_addr.push_back(exp_addr_q[0]);
                        if (exp_last_q[0]) completed++;
                        void'(exp_addr_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end
            if (addr_valid_i && addr_ready_o) model_push(addr_i, len_i, size_i, burst_i);
        end
    end

    task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        int n;
        n = 0;
        addr_i = a; len_i = l; size_i = s; burst_i = b; addr_valid_i = 1'b1;
        @(negedge clk);
        while (!addr_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", addr_ready_o, 1'b1);
        @(posedge clk); #1;
        addr_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_addr_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_addr_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_obs(input string name, input int idx, input logic [31:0] e);
        if (idx < obs_addr.size()) check(name, obs_addr[idx], e);
        else                       check(name, obs_addr.size(), idx + 1);
    endtask

    initial begin
        int gaps;
        int n;
        repeat (2) @(posedge clk); #1;
        check("rst_beat_valid", beat_valid_o, 1'b0);
        check("rst_beat_addr", beat_addr_o, 32'h0);
        check("rst_beat_last", beat_last_o, 1'b0);
        check("rst_burst_id", burst_id_o, 3'b000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_addr_ready", addr_ready_o, 1'b0);
        reset_i = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("addr_ready_after_rst", addr_ready_o, 1'b1);

        // INCR, with first-beat latency
        beat_ready_i = 1'b1;
        obs_addr.delete();
        send(32'h1000, 8'd3, 3'd3, 2'b01);
        @(negedge clk);
        check("lat_cycle1_valid", beat_valid_o, 1'b0);
        @(negedge clk);
        check("lat_cycle2_valid", beat_valid_o, 1'b1);
        drain();
        check_obs("incr_b0", 0, 32'h1000);
        check_obs("incr_b1", 1, 32'h1008);
        check_obs("incr_b2", 2, 32'h1010);
        check_obs("incr_b3", 3, 32'h1018);
        check("incr_id", burst_id_o, 3'b001);

        // WRAP
        obs_addr.delete();
        send(32'h2018, 8'd3, 3'd3, 2'b10);
        drain();
        check_obs("wrap_b0", 0, 32'h2018);
        check_obs("wrap_b1", 1, 32'h2000);
        check_obs("wrap_b2", 2, 32'h2008);
        check_obs("wrap_b3", 3, 32'h2010);
        check("wrap_err", err_o, 1'b0);

        // Engine holds one request, FIFO holds four more
        beat_ready_i = 1'b0;
        obs_addr.delete();
        for (int i = 0; i < 5; i++) send(32'h100 * (i + 1), 8'd1, 3'd2, 2'b01);
        check("full_addr_ready", addr_ready_o, 1'b0);
        check("full_busy", busy_o, 1'b1);
        beat_ready_i = 1'b1;
        gaps = 0;
        repeat (10) begin
            @(negedge clk);
            if (!beat_valid_o) gaps++;
        end
        check("no_bubble", gaps, 0);
        drain();
        check_obs("fill_b9", 9, 32'h504);
        check("fill_id", burst_id_o, 3'b100);

        // Address rollover and FIXED
        obs_addr.delete();
        send(32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01);
        send(32'h3004, 8'd2, 3'd2, 2'b00);
        drain();
        check_obs("roll_b0", 0, 32'hFFFF_FFF8);
        check_obs("roll_b1", 1, 32'h0000_0000);
        check_obs("fixed_b0", 2, 32'h3004);
        check_obs("fixed_b2", 4, 32'h3004);

        // Unsupported requests
        obs_addr.delete();
        send(32'h4000, 8'd1, 3'd2, 2'b11);
        drain();
        check("err_after_rsvd", err_o, 1'b1);
        send(32'h5000, 8'd2, 3'd2, 2'b10);
        send(32'h6000, 8'd1, 3'd5, 2'b01);
        drain();
        check_obs("rsvd_b1", 1, 32'h4004);
        check_obs("badwrap_b2", 4, 32'h5008);
        check_obs("clamp_b1", 6, 32'h6008);
        check("err_sticky", err_o, 1'b1);

        // Reset in the middle of a burst with a request queued behind it
        beat_ready_i = 1'b0;
        obs_addr.delete();
        send(32'h7000, 8'd7, 3'd3, 2'b01);
        send(32'h9000, 8'd0, 3'd3, 2'b01);
        beat_ready_i = 1'b1;
        n = 0;
        while (obs_addr.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", obs_addr.size() >= 2, 1'b1);
        @(posedge clk); #2;
        reset_i = 1'b1;
        #1;
        check("mid_rst_beat_valid", beat_valid_o, 1'b0);
        check("mid_rst_burst_id", burst_id_o, 3'b000);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_err", err_o, 1'b0);
        check("mid_rst_addr_ready", addr_ready_o, 1'b0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        repeat (2) @(posedge clk); #1;
        obs_addr.delete();
        send(32'h8000, 8'd1, 3'd3, 2'b01);
        drain();
        check_obs("post_rst_b0", 0, 32'h8000);
        check_obs("post_rst_b1", 1, 32'h8008);
        check("post_rst_count", obs_addr.size(), 2);
        check("post_rst_id", burst_id_o, 3'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
